// File: rtl/ext_mem_pkg.sv
// Shared types and widths for the external memory slave.
// Imported by the top module and the testbench.
package ext_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        RECOVER
    } state_t;

    localparam int WAIT_W = 4;
    localparam int ERR_W  = 8;

endpackage

// File: rtl/ext_mem_slave_if.sv
// Request/ready signals of the CPU external memory bus.
// The bidirectional data lines stay a plain port on the slave.
interface ext_mem_slave_if;

    logic [31:0] ext_addr;
    logic        ext_mem_read;
    logic        ext_mem_write;
    logic        ext_mem_enable;
    logic        ext_mem_ready;

    modport master (
        output ext_addr,
        output ext_mem_read,
        output ext_mem_write,
        output ext_mem_enable,
        input  ext_mem_ready
    );

    modport slave (
        input  ext_addr,
        input  ext_mem_read,
        input  ext_mem_write,
        input  ext_mem_enable,
        output ext_mem_ready
    );

endinterface

// File: rtl/ext_mem_array.sv
// Word RAM behind the slave.
// Writes are synchronous and reads are asynchronous, so this can be replaced by an FPGA block RAM.
module ext_mem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wData,
    output logic [31:0]   o_rData
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wData;
        end
    end

    assign o_rData = r_mem[i_addr];

endmodule

// File: rtl/ext_mem_slave.sv
// External memory bus slave. It accepts CPU requests, inserts wait states, pulses ready once per
// transaction, and serves each access from a word RAM window or flags it as an error.
module ext_mem_slave
    import ext_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          READ_WAIT   = 2,
    parameter int          WRITE_WAIT  = 1,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic             clk,
    input  logic             rst,
    ext_mem_slave_if.slave   bus,
    inout  wire  [31:0]      io_extData,
    output logic             o_busy,
    output logic [ERR_W-1:0] o_errCount
);

    localparam int                AW        = $clog2(DEPTH_WORDS);
    localparam logic [29:0]       BASE_WORD = BASE_ADDR[31:2];
    localparam logic [WAIT_W-1:0] RD_WAIT   = WAIT_W'(READ_WAIT);
    localparam logic [WAIT_W-1:0] WR_WAIT   = WAIT_W'(WRITE_WAIT);

    state_t            r_state;
    logic [WAIT_W-1:0] r_waitCnt;
    logic [AW-1:0]     r_idx;
    logic [31:0]       r_wData;
    logic              r_isRead;
    logic              r_isWrite;
    logic              r_err;
    logic              r_ready;
    logic              r_busy;
    logic              r_drive;
    logic [ERR_W-1:0]  r_errCount;

    logic [29:0]       w_wordOff;
    logic              w_decErr;
    logic              w_accept;
    logic              w_illegal;
    logic              w_accRead;
    logic              w_accWrite;
    logic [WAIT_W-1:0] w_loadCnt;
    logic              w_we;
    logic [31:0]       w_rData;

    // An address below the base wraps around here and then lands in the out-of-range check.
    assign w_wordOff  = bus.ext_addr[31:2] - BASE_WORD;
    assign w_decErr   = (bus.ext_addr[1:0] != 2'b00) || (w_wordOff[29:AW] != '0);
    assign w_accept   = bus.ext_mem_enable && (bus.ext_mem_read || bus.ext_mem_write);
    assign w_illegal  = bus.ext_mem_read && bus.ext_mem_write;
    assign w_accRead  = bus.ext_mem_read && !bus.ext_mem_write;
    assign w_accWrite = bus.ext_mem_write && !bus.ext_mem_read;
    assign w_loadCnt  = w_illegal ? '0 : (w_accRead ? RD_WAIT : WR_WAIT);

    // The write goes in at the edge that ends RESP, so a reset during the transaction drops it.
    assign w_we = (r_state == RESP) && r_isWrite && !r_err;

    ext_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (r_idx),
        .i_wData (r_wData),
        .o_rData (w_rData)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_waitCnt  <= '0;
            r_idx      <= '0;
            r_wData    <= '0;
            r_isRead   <= 1'b0;
            r_isWrite  <= 1'b0;
            r_err      <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_drive    <= 1'b0;
            r_errCount <= '0;
        end else begin
            r_ready <= 1'b0;
            r_drive <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_isRead  <= w_accRead;
                        r_isWrite <= w_accWrite;
                        r_err     <= w_illegal || w_decErr;
                        r_idx     <= w_wordOff[AW-1:0];
                        r_wData   <= io_extData;
                        r_waitCnt <= w_loadCnt;
                        r_busy    <= 1'b1;
                        if (w_loadCnt == '0) begin
                            r_state <= RESP;
                            r_ready <= 1'b1;
                            r_drive <= w_accRead;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    r_waitCnt <= r_waitCnt - 1'b1;
                    if (r_waitCnt == WAIT_W'(1)) begin
                        r_state <= RESP;
                        r_ready <= 1'b1;
                        r_drive <= r_isRead;
                    end
                end
                RESP: begin
                    r_state <= RECOVER;
                    if (r_err && (r_errCount != '1)) begin
                        r_errCount <= r_errCount + 1'b1;
                    end
                end
                RECOVER: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign io_extData        = r_drive ? (r_err ? ERR_DATA : w_rData) : 'z;
    assign bus.ext_mem_ready = r_ready;
    assign o_busy            = r_busy;
    assign o_errCount        = r_errCount;

endmodule

// File: tb/tb_ext_mem_slave.sv
// Directed testbench for ext_mem_slave. dutA uses the default wait states and dutB uses zero wait states.
// All expected values below are hand-computed.
module tb_ext_mem_slave;

    logic        clk = 1'b0;
    logic        rst;
    int          numChecks = 0;
    int          numPass   = 0;

    ext_mem_slave_if busA ();
    ext_mem_slave_if busB ();

    wire  [31:0] dataA;
    wire  [31:0] dataB;
    logic        driveA, driveB;
    logic [31:0] tbDataA, tbDataB;
    logic        busyA, busyB;
    logic [7:0]  errA, errB;

    int          lat;
    logic [31:0] rdData;
    logic        recReady, recBusy, idleBusy;

    assign dataA = driveA ? tbDataA : 'z;
    assign dataB = driveB ? tbDataB : 'z;

    always #5 clk = ~clk;

    ext_mem_slave dutA (
        .clk        (clk),
        .rst        (rst),
        .bus        (busA.slave),
        .io_extData (dataA),
        .o_busy     (busyA),
        .o_errCount (errA)
    );

    ext_mem_slave #(
        .READ_WAIT  (0),
        .WRITE_WAIT (0)
    ) dutB (
        .clk        (clk),
        .rst        (rst),
        .bus        (busB.slave),
        .io_extData (dataB),
        .o_busy     (busyB),
        .o_errCount (errB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numChecks++;
        if (obs === exp) numPass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    // Issues one request on dutA, holds it until ready, and returns the latency counted in cycles after the accept edge.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, output int latOut, output logic [31:0] dOut);
        busA.ext_mem_enable = 1'b1;
        busA.ext_mem_read   = rd;
        busA.ext_mem_write  = wr;
        busA.ext_addr       = addr;
        tbDataA             = wdata;
        driveA              = wr;
        latOut              = 0;
        dOut                = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busA.ext_mem_ready) begin
                latOut = i;
                dOut   = dataA;
                break;
            end
        end
        busA.ext_mem_enable = 1'b0;
        busA.ext_mem_read   = 1'b0;
        busA.ext_mem_write  = 1'b0;
        driveA              = 1'b0;
        @(negedge clk);
        recReady = busA.ext_mem_ready;
        recBusy  = busyA;
        @(negedge clk);
        idleBusy = busyA;
    endtask

    task automatic waitReadyB(output int n, output logic [31:0] d);
        n = 0;
        d = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busB.ext_mem_ready) begin
                n = i;
                d = dataB;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        busA.ext_mem_enable = 1'b0; busA.ext_mem_read = 1'b0; busA.ext_mem_write = 1'b0; busA.ext_addr = '0;
        busB.ext_mem_enable = 1'b0; busB.ext_mem_read = 1'b0; busB.ext_mem_write = 1'b0; busB.ext_addr = '0;
        driveA = 1'b0; driveB = 1'b0; tbDataA = '0; tbDataB = '0;
        #2 rst = 1'b1;
        #1;
        checkOutput("rstReady", {31'd0, busA.ext_mem_ready}, 32'd0);
        checkOutput("rstBusy", {31'd0, busyA}, 32'd0);
        checkOutput("rstErr", {24'd0, errA}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Write then read with the default wait states.
        applyStimulus(1'b0, 1'b1, 32'h0001_0004, 32'h0000_2710, lat, rdData);
        checkOutput("wrLat", 32'(lat), 32'd2);
        checkOutput("recoverReady", {31'd0, recReady}, 32'd0);
        checkOutput("recoverBusy", {31'd0, recBusy}, 32'd1);
        checkOutput("idleBusy", {31'd0, idleBusy}, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0001_0004, 32'h0, lat, rdData);
        checkOutput("rdLat", 32'(lat), 32'd3);
        checkOutput("rdData", rdData, 32'h0000_2710);
        checkOutput("errAfterGood", {24'd0, errA}, 32'd0);

        // Zero wait states on dutB: one write, then two reads with the request held back-to-back.
        busB.ext_mem_enable = 1'b1; busB.ext_mem_write = 1'b1; busB.ext_addr = 32'h0001_0010;
        tbDataB = 32'h0BAD_F00D; driveB = 1'b1;
        waitReadyB(lat, rdData);
        checkOutput("bWrLat", 32'(lat), 32'd1);
        busB.ext_mem_enable = 1'b0; busB.ext_mem_write = 1'b0; driveB = 1'b0;
        repeat (2) @(negedge clk);
        busB.ext_mem_enable = 1'b1; busB.ext_mem_read = 1'b1;
        waitReadyB(lat, rdData);
        checkOutput("bRd1Lat", 32'(lat), 32'd1);
        checkOutput("bRd1Data", rdData, 32'h0BAD_F00D);
        waitReadyB(lat, rdData);
        checkOutput("bRdGap", 32'(lat), 32'd3);
        checkOutput("bRd2Data", rdData, 32'h0BAD_F00D);
        busB.ext_mem_enable = 1'b0; busB.ext_mem_read = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("bErr", {24'd0, errB}, 32'd0);

        // Error cases.
        applyStimulus(1'b0, 1'b1, 32'h0001_0000, 32'hAAAA_5555, lat, rdData);
        applyStimulus(1'b1, 1'b0, 32'h0001_0002, 32'h0, lat, rdData);
        checkOutput("misalignData", rdData, 32'hDEAD_BEEF);
        checkOutput("errRdLat", 32'(lat), 32'd3);
        applyStimulus(1'b1, 1'b0, 32'h0000_FFFC, 32'h0, lat, rdData);
        checkOutput("belowBaseData", rdData, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b1, 32'h0001_1000, 32'h5555_AAAA, lat, rdData);
        applyStimulus(1'b1, 1'b0, 32'h0001_0000, 32'h0, lat, rdData);
        checkOutput("oorWriteNoEffect", rdData, 32'hAAAA_5555);
        checkOutput("errCount3", {24'd0, errA}, 32'd3);

        // An illegal request with both read and write asserted.
        applyStimulus(1'b1, 1'b1, 32'h0001_0000, 32'h1111_1111, lat, rdData);
        checkOutput("illegalLat", 32'(lat), 32'd1);
        checkOutput("errCount4", {24'd0, errA}, 32'd4);
        applyStimulus(1'b1, 1'b0, 32'h0001_0000, 32'h0, lat, rdData);
        checkOutput("illegalNoWrite", rdData, 32'hAAAA_5555);

        // Reset asserted in the WAIT state of a write.
        applyStimulus(1'b0, 1'b1, 32'h0001_0008, 32'hCAFE_0008, lat, rdData);
        busA.ext_mem_enable = 1'b1; busA.ext_mem_write = 1'b1; busA.ext_addr = 32'h0001_0008;
        tbDataA = 32'h1234_5678; driveA = 1'b1;
        @(negedge clk);
        checkOutput("busyInWait", {31'd0, busyA}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rstMidBusy", {31'd0, busyA}, 32'd0);
        checkOutput("rstMidReady", {31'd0, busA.ext_mem_ready}, 32'd0);
        busA.ext_mem_enable = 1'b0; busA.ext_mem_write = 1'b0; driveA = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0001_0008, 32'h0, lat, rdData);
        checkOutput("rstDiscardWrite", rdData, 32'hCAFE_0008);
        checkOutput("errAfterRst", {24'd0, errA}, 32'd0);

        // err_count saturates at 255.
        for (int i = 0; i < 255; i++) applyStimulus(1'b1, 1'b0, 32'h0001_0002, 32'h0, lat, rdData);
        checkOutput("errCount255", {24'd0, errA}, 32'd255);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 32'h0001_0002, 32'h0, lat, rdData);
        checkOutput("errSaturate", {24'd0, errA}, 32'd255);

        $display("%0d/%0d checks passed", numPass, numChecks);
        $finish;
    end

endmodule

// File: doc/ext_mem_slave.md
Name: ext_mem_slave

Overview:
- Slave-side model and controller for the CPU's external memory bus. It sits directly downstream of microprocessor_system and consumes ext_addr, ext_data, ext_mem_read, ext_mem_write and ext_mem_enable.
- Produces ext_mem_ready completion pulses after a programmable number of wait states.
- Backs accesses with a word-addressed RAM window and flags protocol and range errors.
- Used in system benches and FPGA builds in place of a constant-high ready tie-off.

Parameters:
- BASE_ADDR, 32'h0001_0000, byte address of word 0 of the window.
- DEPTH_WORDS, 1024, RAM size in 32-bit words; must be a power of two.
- READ_WAIT, 2, wait cycles inserted before a read completes (0..15).
- WRITE_WAIT, 1, wait cycles inserted before a write completes (0..15).
- ERR_DATA, 32'hDEAD_BEEF, data returned on an errored read.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- ext_addr  input  32  byte address from the CPU.
- ext_data  inout  32  bidirectional data. The block drives it only in the RESP cycle of a read and is high-Z otherwise.
- ext_mem_read  input  1  read request.
- ext_mem_write  input  1  write request.
- ext_mem_enable  input  1  bus cycle qualifier.
- ext_mem_ready  output  1  one-cycle completion pulse.
- busy  output  1  high in any state other than IDLE.
- err_count  output  8  saturating count of errored transactions.

Behaviour:
- Reset values: ext_mem_ready=0, busy=0, err_count=0, ext_data released (high-Z), state=IDLE. RAM contents are not cleared.
- Clock and reset: one clock. Reset is asynchronous and active-high.
- States: IDLE, WAIT, RESP, RECOVER.
- IDLE:
  - A request is accepted on a rising edge where ext_mem_enable=1 and exactly one of read/write is 1.
  - On acceptance, capture the address, the op, and ext_data (writes only), and load the wait counter with READ_WAIT or WRITE_WAIT.
  - If the loaded wait count is 0, go to RESP; otherwise go to WAIT.
- Illegal request: enable=1 with read=1 and write=1.
  - Accepted as an errored transaction with no RAM access and WAIT=0.
  - Goes to RESP and pulses ready so the CPU cannot hang.
- No request: enable=1 with neither read nor write is ignored; the block stays in IDLE.
- WAIT: decrement the counter each cycle; move to RESP when it reaches 1.
  - Total latency from the accept edge to the ready-high cycle is 1+WAIT cycles.
- RESP: ext_mem_ready=1 for exactly one cycle.
  - Read: ext_data = RAM[idx], or ERR_DATA if errored.
  - Write: RAM[idx] is written at the end of the RESP cycle unless errored.
  - Next state is RECOVER.
- RECOVER: one cycle with ready=0 and bus released. Request lines are ignored because the CPU drops them this cycle. Next state is IDLE.
  - Back-to-back throughput is therefore one transaction per 3+WAIT cycles.
- Address decode: idx = (addr - BASE_ADDR) >> 2, computed as a 32-bit unsigned subtract.
  - Error if addr[1:0] != 0.
  - Error if addr < BASE_ADDR (the subtract wraps around and fails the range check).
  - Error if idx >= DEPTH_WORDS.
- err_count: incremented by 1 in the RESP cycle of every errored transaction. It saturates at 255 and never wraps.
- Captured values: request lines changing during WAIT or RESP have no effect; the captured address, op and data are used.
- Reset mid-transaction: immediate return to IDLE, ready deasserted, bus released, and any pending write discarded (RAM unchanged).
- Bus contention: ext_data is never driven outside a read's RESP cycle, including during reset.

Decomposition:
- Package ext_mem_pkg holds:
  - the state enum (IDLE, WAIT, RESP, RECOVER);
  - the wait counter width constant (4);
  - the err_count width constant (8).
- Sub-module ext_mem_array is the natural split: a synchronous-write, asynchronous-read RAM of DEPTH_WORDS x 32.
  - It keeps the storage swappable for an FPGA block RAM.
  - Its read port is sampled in RESP, so a registered read variant must present its address in the last WAIT cycle.

Test Plan:
- Write then read:
  - Write 32'h0000_2710 to 32'h0001_0004 with WRITE_WAIT=1: ready pulses 2 cycles after accept.
  - Read of the same address with READ_WAIT=2 returns 32'h0000_2710 with ready 3 cycles after accept; err_count stays 0.
- Zero wait and back-to-back:
  - READ_WAIT=WRITE_WAIT=0, two consecutive reads held until ready: ready in the cycle after each accept.
  - The second accept occurs exactly 3 cycles after the first; RECOVER ignores the still-held request.
- Errors:
  - Read of 32'h0001_0002 returns 32'hDEAD_BEEF.
  - Read of 32'h0000_FFFC (below base) returns 32'hDEAD_BEEF.
  - Write to 32'h0001_1000 with DEPTH_WORDS=1024 leaves RAM unchanged.
  - err_count=3 afterwards.
- Illegal request: read=1 and write=1 at 32'h0001_0000 → ready after 1 cycle, no RAM change, err_count +1.
- Saturation: 260 errored reads → err_count=255.
- Reset mid-write:
  - Assert rst during WAIT of a write of 32'h1234_5678 to 32'h0001_0008.
  - busy and ready go to 0 immediately; a later read of 32'h0001_0008 returns the prior contents.
